// File: rtl/display7_segment_capture_pkg.sv
// Shared definitions for the 7-segment capture path: segment bit positions,
// the sixteen hex glyphs (active-high {g,f,e,d,c,b,a}) and the forward
// hex-to-segment decoder that the pattern encoder inverts.
package display7_segment_capture_pkg;

  // Segment bit positions on the {dp,g,f,e,d,c,b,a} bus
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Nibble reported for a pattern that is not a legal glyph
  localparam logic [3:0] ERR_NIBBLE = 4'h0;

  // Active-high glyphs, bit 0 = segment a
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // Result of decoding one digit pattern
  typedef struct packed {
    logic [3:0] nibble;
    logic       err;
  } enc_t;

  // Forward decoder used by the display driver; the capture side inverts it
  function automatic logic [6:0] hex_to_glyph(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'h0:    glyph = GLYPH_0;
      4'h1:    glyph = GLYPH_1;
      4'h2:    glyph = GLYPH_2;
      4'h3:    glyph = GLYPH_3;
      4'h4:    glyph = GLYPH_4;
      4'h5:    glyph = GLYPH_5;
      4'h6:    glyph = GLYPH_6;
      4'h7:    glyph = GLYPH_7;
      4'h8:    glyph = GLYPH_8;
      4'h9:    glyph = GLYPH_9;
      4'hA:    glyph = GLYPH_A;
      4'hB:    glyph = GLYPH_B;
      4'hC:    glyph = GLYPH_C;
      4'hD:    glyph = GLYPH_D;
      4'hE:    glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/display7_segment_capture_encoder.sv
// Combinational inverse of the hex-to-segment decoder: maps an active-high
// 7-bit segment pattern back to its hex nibble, flagging unknown patterns.
module seg7_pattern_encoder
  import display7_segment_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err
);

  enc_t res;

  // Search the shared glyph table; glyphs are unique so at most one matches
  always_comb begin
    res.nibble = ERR_NIBBLE;
    res.err    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pattern == hex_to_glyph(4'(i))) begin
        res.nibble = 4'(i);
        res.err    = 1'b0;
      end
    end
  end

  assign nibble = res.nibble;
  assign err    = res.err;

endmodule

// File: rtl/display7_segment_capture.sv
// Receive end of a multiplexed 7-segment bus. Synchronises the snooped
// segment/anode lines, waits for each digit to dwell long enough, decodes
// the pattern back to a nibble and publishes complete frames on a
// valid/ready interface with a sticky overrun flag.
module display7_segment_capture
  import display7_segment_capture_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_i,
  input  logic [DIGITS-1:0]     an_i,
  input  logic                  frame_ready_i,
  input  logic                  clear_overrun_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic [DIGITS-1:0]     dp_o,
  output logic [DIGITS-1:0]     err_o,
  output logic                  frame_valid_o,
  output logic                  overrun_o
);

  localparam int                CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  // Pin levels of an unlit bus with no digit enabled
  localparam logic [7:0]        SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_IDLE  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                : {DIGITS{1'b0}};

  // Synchroniser stages (pin polarity)
  logic [7:0]          seg_p0, seg_p1;
  logic [DIGITS-1:0]   an_p0, an_p1;

  // Normalised sample: lit = 1, enabled = 1
  logic [7:0]          seg_norm;
  logic [DIGITS-1:0]   an_norm;

  // Held sample for the current dwell and its stability tracking
  logic [7:0]          seg_p2;
  logic [DIGITS-1:0]   an_p2;
  logic [CNT_W-1:0]    stable_cnt;
  logic                captured;

  logic                changed;
  logic                an_onehot;
  logic                capture;
  logic [DIGITS-1:0]   capture_mask;

  // Decoded view of the held pattern
  logic [3:0]          enc_nibble;
  logic                enc_err;

  // Per-digit slots for the frame under assembly
  logic [4*DIGITS-1:0] slot_val;
  logic [DIGITS-1:0]   slot_dp;
  logic [DIGITS-1:0]   slot_err;
  logic [DIGITS-1:0]   seen;
  logic                frame_done;

  // ---- stage p0/p1: two-flop synchroniser on the asynchronous bus ----
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p0 <= SEG_IDLE;
      seg_p1 <= SEG_IDLE;
      an_p0  <= AN_IDLE;
      an_p1  <= AN_IDLE;
    end else begin
      seg_p0 <= seg_i;
      seg_p1 <= seg_p0;
      an_p0  <= an_i;
      an_p1  <= an_p0;
    end
  end

  assign seg_norm = (SEG_ACTIVE_LOW != 0) ? ~seg_p1 : seg_p1;
  assign an_norm  = (AN_ACTIVE_LOW != 0)  ? ~an_p1  : an_p1;

  assign changed   = ({seg_norm, an_norm} != {seg_p2, an_p2});
  assign an_onehot = (an_p2 != '0) && ((an_p2 & (an_p2 - 1'b1)) == '0);
  // The held sample plus STABLE_CYCLES-1 matching followers make a full dwell
  assign capture   = an_onehot && (stable_cnt == CNT_MAX) && !captured;
  assign capture_mask = capture ? an_p2 : '0;

  // ---- stage p2: dwell tracking on the normalised sample ----
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p2     <= '0;
      an_p2      <= '0;
      stable_cnt <= '0;
      captured   <= 1'b0;
    end else if (changed) begin
      seg_p2     <= seg_norm;
      an_p2      <= an_norm;
      stable_cnt <= '0;
      captured   <= 1'b0;
    end else begin
      if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
      if (capture) begin
        captured <= 1'b1;
      end
    end
  end

  seg7_pattern_encoder u_encoder (
    .pattern (seg_p2[SEG_G:SEG_A]),
    .nibble  (enc_nibble),
    .err     (enc_err)
  );

  assign frame_done = &seen;

  // Track which digits hold fresh data; a publish empties the set
  always_ff @(posedge clk) begin
    if (rst) begin
      seen <= '0;
    end else begin
      seen <= (frame_done ? '0 : seen) | capture_mask;
    end
  end

  // ---- stage p3: slot write, last capture of a digit wins ----
  always_ff @(posedge clk) begin
    for (int k = 0; k < DIGITS; k++) begin
      if (capture_mask[k]) begin
        slot_val[4*k +: 4] <= enc_nibble;
        slot_dp[k]         <= seg_p2[SEG_DP];
        slot_err[k]        <= enc_err;
      end
    end
  end

  // ---- stage p4: publish complete frames and run the handshake ----
  always_ff @(posedge clk) begin
    if (rst) begin
      value_o       <= '0;
      dp_o          <= '0;
      err_o         <= '0;
      frame_valid_o <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      if (frame_done && (!frame_valid_o || frame_ready_i)) begin
        value_o       <= slot_val;
        dp_o          <= slot_dp;
        err_o         <= slot_err;
        frame_valid_o <= 1'b1;
      end else if (frame_valid_o && frame_ready_i) begin
        frame_valid_o <= 1'b0;
      end

      // A new frame arriving while the old one is stuck is dropped and flagged
      if (frame_done && frame_valid_o && !frame_ready_i) begin
        overrun_o <= 1'b1;
      end else if (clear_overrun_i) begin
        overrun_o <= 1'b0;
      end
    end
  end

endmodule
